plat_land_scan: RTL and testbench

Consumes the platform configuration produced by the block generator: the per-block packed platform x, y and length vectors plus the block index `camera_y`. On each physics tick it sequentially scans the current block's platforms and reports whether the falling character lands on one. If it lands, the block returns the snapped landing height and the platform index. It sits between the block generator and the character physics update, on the read side of the platform-configuration interface.

---
 rtl/plat_land_scan.sv | 164 ++++++++++++++++
 tb/tb_plat_land_scan.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/plat_land_scan.sv
`default_nettype none
// ============================================================================
// Module      : plat_land_scan
// Description : Sequential per-tick landing test of a falling character
//               against the current block's platforms; reports the top hit.
// Revision    : 1.0 - initial release
// ============================================================================
module plat_land_scan #(
    parameter int PLATFORM_NUM_PER_BLOCK = 7,
    parameter int PHY_WIDTH              = 14,
    parameter int BLOCK_LEN_WIDTH        = 4,
    parameter int BLOCK_WIDTH            = 480,
    parameter int TILE_WIDTH             = 8,
    parameter int CHAR_WIDTH             = 16
) (
    input  logic                                         sys_clk,
    input  logic                                         sys_rst,
    input  logic                                         start,
    input  logic signed [PHY_WIDTH:0]                    abs_char_x,
    input  logic signed [PHY_WIDTH:0]                    abs_char_y,
    input  logic signed [PHY_WIDTH:0]                    char_vy,
    input  logic        [4:0]                            camera_y,
    input  logic                                         block_switch,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]  plat_relative_x,
    input  logic [PLATFORM_NUM_PER_BLOCK*PHY_WIDTH-1:0]  plat_relative_y,
    input  logic [PLATFORM_NUM_PER_BLOCK*BLOCK_LEN_WIDTH-1:0] plat_len,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         landed,
    output logic signed [PHY_WIDTH:0]                    land_y,
    output logic        [2:0]                            land_idx
);

    localparam int AW = PHY_WIDTH + 2;
    localparam int XW = PLATFORM_NUM_PER_BLOCK * PHY_WIDTH;
    localparam int LW = PLATFORM_NUM_PER_BLOCK * BLOCK_LEN_WIDTH;
    localparam logic [2:0] LAST_IDX = 3'(PLATFORM_NUM_PER_BLOCK - 1);
    localparam logic signed [AW-1:0] CHAR_W_S = AW'(CHAR_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                   state_q;
    logic [2:0]               idx_q;
    logic signed [PHY_WIDTH:0] char_x_q, char_y_q, vy_q;
    logic [XW-1:0]            px_q, py_q;
    logic [LW-1:0]            pl_q;
    logic [4:0]               cam_q;
    logic                     found_q;
    logic signed [AW-1:0]     best_y_q;
    logic [2:0]               best_idx_q;
    logic                     busy_q, done_q, landed_q;
    logic signed [PHY_WIDTH:0] land_y_q;
    logic [2:0]               land_idx_q;

    logic [PHY_WIDTH-1:0]       rel_x_d, rel_y_d;
    logic [BLOCK_LEN_WIDTH-1:0] len_d;
    logic signed [AW-1:0]       top_d, left_d, right_d, cx_d, cxr_d, cy_d, ny_d;
    logic                       hit_d, take_d;

    // Every operand is widened to AW bits so block offset 31 cannot overflow.
    always_comb begin
        rel_x_d = px_q[int'(idx_q)*PHY_WIDTH +: PHY_WIDTH];
        rel_y_d = py_q[int'(idx_q)*PHY_WIDTH +: PHY_WIDTH];
        len_d   = pl_q[int'(idx_q)*BLOCK_LEN_WIDTH +: BLOCK_LEN_WIDTH];
        top_d   = signed'(AW'(cam_q) * AW'(BLOCK_WIDTH) + AW'(rel_y_d));
        left_d  = signed'(AW'(rel_x_d));
        right_d = signed'(AW'(rel_x_d) + AW'(len_d) * AW'(TILE_WIDTH));
        cx_d    = {char_x_q[PHY_WIDTH], char_x_q};
        cy_d    = {char_y_q[PHY_WIDTH], char_y_q};
        ny_d    = cy_d + {vy_q[PHY_WIDTH], vy_q};
        cxr_d   = cx_d + CHAR_W_S;
        hit_d   = vy_q[PHY_WIDTH] && (len_d != '0) && (cy_d >= top_d) &&
                  (ny_d < top_d) && (cx_d < right_d) && (cxr_d > left_d);
        take_d  = hit_d && (!found_q || (top_d > best_y_q));
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            char_x_q   <= '0;
            char_y_q   <= '0;
            vy_q       <= '0;
            px_q       <= '0;
            py_q       <= '0;
            pl_q       <= '0;
            cam_q      <= '0;
            found_q    <= 1'b0;
            best_y_q   <= '0;
            best_idx_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            landed_q   <= 1'b0;
            land_y_q   <= '0;
            land_idx_q <= '0;
        end else begin
            busy_q <= (state_q == S_SCAN);
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        char_x_q   <= abs_char_x;
                        char_y_q   <= abs_char_y;
                        vy_q       <= char_vy;
                        px_q       <= plat_relative_x;
                        py_q       <= plat_relative_y;
                        pl_q       <= plat_len;
                        cam_q      <= camera_y;
                        found_q    <= 1'b0;
                        best_y_q   <= '0;
                        best_idx_q <= '0;
                        idx_q      <= '0;
                        state_q    <= S_SCAN;
                    end
                end
                S_SCAN: begin
                    // A block change restarts the scan on the new platforms
                    // but keeps the character snapshot taken at start.
                    if (block_switch) begin
                        px_q       <= plat_relative_x;
                        py_q       <= plat_relative_y;
                        pl_q       <= plat_len;
                        cam_q      <= camera_y;
                        found_q    <= 1'b0;
                        best_y_q   <= '0;
                        best_idx_q <= '0;
                        idx_q      <= '0;
                    end else begin
                        if (take_d) begin
                            found_q    <= 1'b1;
                            best_y_q   <= top_d;
                            best_idx_q <= idx_q;
                        end
                        if (idx_q == LAST_IDX) begin
                            state_q <= S_DONE;
                        end else begin
                            idx_q <= idx_q + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    done_q     <= 1'b1;
                    landed_q   <= found_q;
                    land_y_q   <= found_q ? best_y_q[PHY_WIDTH:0] : '0;
                    land_idx_q <= found_q ? best_idx_q : '0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign landed   = landed_q;
    assign land_y   = land_y_q;
    assign land_idx = land_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_plat_land_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_plat_land_scan
// Description : Directed scoreboard bench for plat_land_scan.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_plat_land_scan;

    localparam int PN = 7;
    localparam int PW = 14;
    localparam int LW = 4;

    logic                 clk, rst, start, block_switch;
    logic signed [PW:0]   abs_char_x, abs_char_y, char_vy;
    logic [4:0]           camera_y;
    logic [PN*PW-1:0]     plat_relative_x, plat_relative_y;
    logic [PN*LW-1:0]     plat_len;
    logic                 busy, done, landed;
    logic signed [PW:0]   land_y;
    logic [2:0]           land_idx;

    typedef struct {
        int l;
        int y;
        int i;
        int c;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    plat_land_scan dut (
        .sys_clk         (clk),
        .sys_rst         (rst),
        .start           (start),
        .abs_char_x      (abs_char_x),
        .abs_char_y      (abs_char_y),
        .char_vy         (char_vy),
        .camera_y        (camera_y),
        .block_switch    (block_switch),
        .plat_relative_x (plat_relative_x),
        .plat_relative_y (plat_relative_y),
        .plat_len        (plat_len),
        .busy            (busy),
        .done            (done),
        .landed          (landed),
        .land_y          (land_y),
        .land_idx        (land_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("landed", int'(landed), e.l);
                chk("land_y", int'(land_y), e.y);
                chk("land_idx", int'(land_idx), e.i);
                chk("done_cycle", cyc, e.c);
            end
        end
    end

    task automatic clear_plats();
        plat_relative_x = '0;
        plat_relative_y = '0;
        plat_len        = '0;
    endtask

    task automatic set_plat(input int i, input int x, input int y, input int len);
        plat_relative_x[i*PW +: PW] = PW'(x);
        plat_relative_y[i*PW +: PW] = PW'(y);
        plat_len[i*LW +: LW]        = LW'(len);
    endtask

    task automatic set_char(input int x, input int y, input int vy);
        abs_char_x = 15'(x);
        abs_char_y = 15'(y);
        char_vy    = 15'(vy);
    endtask

    task automatic do_scan(input int el, input int ey, input int ei);
        int t;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; t = cyc;
        sb.push_back('{el, ey, ei, t + 8});
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1; chk("busy_first", int'(busy), 1);
        repeat (6) @(posedge clk);
        #1; chk("busy_last", int'(busy), 1);
        @(posedge clk); #1; chk("busy_clear", int'(busy), 0);
        repeat (2) @(posedge clk);
    endtask

    task automatic basic_setup();
        clear_plats();
        camera_y = 5'd0;
        set_plat(0, 250, 60, 10);
        set_char(260, 62, -5);
    endtask

    initial begin
        int t;
        rst = 1'b1; start = 1'b0; block_switch = 1'b0;
        camera_y = '0;
        set_char(0, 0, 0);
        clear_plats();
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_landed", int'(landed), 0);
        chk("rst_land_y", int'(land_y), 0);
        chk("rst_land_idx", int'(land_idx), 0);
        rst = 1'b0;

        // basic hit and x-edge cases
        basic_setup();              do_scan(1, 60, 0);
        set_char(260, 62, 5);       do_scan(0, 0, 0);
        set_char(330, 62, -5);      do_scan(0, 0, 0);
        set_char(234, 62, -5);      do_scan(0, 0, 0);
        set_char(235, 62, -5);      do_scan(1, 60, 0);
        set_char(329, 62, -5);      do_scan(1, 60, 0);
        set_char(260, 61, -1);      do_scan(0, 0, 0);

        // multiple hits and tie handling
        clear_plats();
        set_plat(2, 90, 140, 4);
        set_plat(5, 80, 135, 5);
        set_char(100, 141, -20);    do_scan(1, 140, 2);
        set_plat(5, 80, 140, 5);    do_scan(1, 140, 2);
        set_plat(2, 90, 135, 4);    do_scan(1, 140, 5);

        // maximum block offset
        clear_plats();
        camera_y = 5'd31;
        set_plat(3, 100, 380, 2);
        set_char(105, 15265, -10);  do_scan(1, 15260, 3);

        // block_switch three cycles into the scan
        basic_setup();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; t = cyc;
        sb.push_back('{1, 58, 1, t + 11});
        @(negedge clk); start = 1'b0; set_char(260, 62, 5);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        clear_plats();
        set_plat(1, 255, 58, 2);
        block_switch = 1'b1;
        @(posedge clk);
        @(negedge clk); block_switch = 1'b0;
        repeat (12) @(posedge clk);

        // start while busy and while in DONE is dropped
        basic_setup();
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1; t = cyc;
        sb.push_back('{1, 60, 0, t + 8});
        @(negedge clk); start = 1'b0; set_char(260, 62, 5);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (20) @(posedge clk);

        // reset mid-scan aborts with no done
        basic_setup();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_landed", int'(landed), 0);
        chk("abort_land_y", int'(land_y), 0);
        chk("abort_land_idx", int'(land_idx), 0);
        @(negedge clk); rst = 1'b0;
        repeat (15) @(posedge clk);

        basic_setup();              do_scan(1, 60, 0);

        repeat (5) @(posedge clk);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_done: got no done expected one at cycle %0d", e.c);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
